// File: rtl/smbs_frame_ctrl_if.sv
// Signal bundle between the serial stream source/consumers and the frame sequencer.
interface smbs_frame_ctrl_if #(
    parameter int PORT_W = 4,
    parameter int LINE_W = 2,
    parameter int SIZE_W = 6
);
    logic              serIn;
    logic              address_en;
    logic              size_en;
    logic              send_en;
    logic [PORT_W-1:0] port;
    logic [LINE_W-1:0] line;
    logic [SIZE_W-1:0] size;
    logic              busy;
    logic              frame_done;

    modport master (
        output serIn,
        input  address_en, size_en, send_en, port, line, size, busy, frame_done
    );

    modport slave (
        input  serIn,
        output address_en, size_en, send_en, port, line, size, busy, frame_done
    );
endinterface

// File: rtl/smbs_frame_ctrl.sv
// Frame sequencer: detects the start bit, steps through address/size/payload
// phases, latches the decoded header fields and enforces an inter-frame guard gap.
module smbs_frame_ctrl #(
    parameter int PORT_W = 4,
    parameter int LINE_W = 2,
    parameter int SIZE_W = 6,
    parameter int GAP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    smbs_frame_ctrl_if.slave   bus
);
    localparam int AL    = PORT_W + LINE_W;
    localparam int CW_A  = $clog2(AL + 1);
    localparam int CW_G  = $clog2(GAP + 1);
    localparam int CW_AG = (CW_A > CW_G) ? CW_A : CW_G;
    localparam int CNT_W = (SIZE_W > CW_AG) ? SIZE_W : CW_AG;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AL - 1);
    localparam logic [CNT_W-1:0] SIZE_LAST = CNT_W'(SIZE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        SIZE,
        PAYLOAD,
        GUARD
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [AL-1:0]     addr_sh_q;
    logic [SIZE_W-1:0] size_sh_q;
    logic [AL-1:0]     addr_d;
    logic [SIZE_W-1:0] size_d;
    logic [PORT_W-1:0] port_q;
    logic [LINE_W-1:0] line_q;
    logic [SIZE_W-1:0] size_q;
    logic              address_en_q;
    logic              size_en_q;
    logic              send_en_q;
    logic              busy_q;
    logic              frame_done_q;

    // Shadow value including the bit currently on serIn, so the last bit lands in the load.
    assign addr_d = AL'({addr_sh_q, bus.serIn});
    assign size_d = SIZE_W'({size_sh_q, bus.serIn});

    always_ff @(posedge clk) begin
        if (state_q == ADDR) addr_sh_q <= addr_d;
        if (state_q == SIZE) size_sh_q <= size_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            port_q       <= '0;
            line_q       <= '0;
            size_q       <= '0;
            address_en_q <= 1'b0;
            size_en_q    <= 1'b0;
            send_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.serIn) begin
                        state_q      <= ADDR;
                        cnt_q        <= '0;
                        address_en_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ADDR: begin
                    if (cnt_q == ADDR_LAST) begin
                        {port_q, line_q} <= addr_d;
                        state_q          <= SIZE;
                        cnt_q            <= '0;
                        address_en_q     <= 1'b0;
                        size_en_q        <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SIZE: begin
                    if (cnt_q == SIZE_LAST) begin
                        size_q    <= size_d;
                        size_en_q <= 1'b0;
                        if (size_d != '0) begin
                            state_q   <= PAYLOAD;
                            cnt_q     <= CNT_W'(1);
                            send_en_q <= 1'b1;
                        end else begin
                            frame_done_q <= 1'b1;
                            if (GAP > 0) begin
                                state_q <= GUARD;
                                cnt_q   <= CNT_W'(1);
                            end else begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (cnt_q == CNT_W'(size_q)) begin
                        send_en_q    <= 1'b0;
                        frame_done_q <= 1'b1;
                        if (GAP > 0) begin
                            state_q <= GUARD;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    address_en_q <= 1'b0;
                    size_en_q    <= 1'b0;
                    send_en_q    <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.address_en = address_en_q;
    assign bus.size_en    = size_en_q;
    assign bus.send_en    = send_en_q;
    assign bus.port       = port_q;
    assign bus.line       = line_q;
    assign bus.size       = size_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_smbs_frame_ctrl.sv
// Bench for smbs_frame_ctrl: three instances (GAP=1, GAP=3, GAP=0) driven by directed frames.
module tb_smbs_frame_ctrl;
    logic clk;
    logic rst;
    logic ser;
    int   sel;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    typedef struct {
        int         k;
        logic [3:0] p;
        logic [1:0] l;
        logic [5:0] s;
    } exp_t;

    exp_t q[$];

    logic       aen [3];
    logic       sen [3];
    logic       snd [3];
    logic       bsy [3];
    logic       fd  [3];
    logic [3:0] pt  [3];
    logic [1:0] ln  [3];
    logic [5:0] sz  [3];

    logic [5:0] last_pl [3];
    logic [5:0] last_sz [3];

    int ca [3];
    int cs [3];
    int cd [3];

    smbs_frame_ctrl_if if0 ();
    smbs_frame_ctrl_if if1 ();
    smbs_frame_ctrl_if if2 ();

    smbs_frame_ctrl #(.GAP(1)) u_gap1 (.clk(clk), .rst(rst), .bus(if0));
    smbs_frame_ctrl #(.GAP(3)) u_gap3 (.clk(clk), .rst(rst), .bus(if1));
    smbs_frame_ctrl #(.GAP(0)) u_gap0 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.serIn = (sel == 0) ? ser : 1'b1;
    assign if1.serIn = (sel == 1) ? ser : 1'b1;
    assign if2.serIn = (sel == 2) ? ser : 1'b1;

    assign aen[0] = if0.address_en; assign aen[1] = if1.address_en; assign aen[2] = if2.address_en;
    assign sen[0] = if0.size_en;    assign sen[1] = if1.size_en;    assign sen[2] = if2.size_en;
    assign snd[0] = if0.send_en;    assign snd[1] = if1.send_en;    assign snd[2] = if2.send_en;
    assign bsy[0] = if0.busy;       assign bsy[1] = if1.busy;       assign bsy[2] = if2.busy;
    assign fd[0]  = if0.frame_done; assign fd[1]  = if1.frame_done; assign fd[2]  = if2.frame_done;
    assign pt[0]  = if0.port;       assign pt[1]  = if1.port;       assign pt[2]  = if2.port;
    assign ln[0]  = if0.line;       assign ln[1]  = if1.line;       assign ln[2]  = if2.line;
    assign sz[0]  = if0.size;       assign sz[1]  = if1.size;       assign sz[2]  = if2.size;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] en_vec(input int k);
        return {aen[k], sen[k], snd[k]};
    endfunction

    function automatic logic [16:0] out_all(input int k);
        return {bsy[k], aen[k], sen[k], snd[k], fd[k], pt[k], ln[k], sz[k]};
    endfunction

    task automatic step(input logic b);
        ser = b;
        @(posedge clk);
        #1;
    endtask

    // Drives one frame into instance k; returns in the frame_done cycle (or after the abort).
    task automatic send_frame(input int k, input logic [3:0] p, input logic [1:0] l,
                              input logic [5:0] s, input bit abort);
        logic [5:0] pl;
        exp_t       e;
        pl  = {p, l};
        sel = k;
        if (!abort) begin
            e.k = k; e.p = p; e.l = l; e.s = s;
            q.push_back(e);
        end
        step(1'b0);
        chk("start_latency_en", 32'(en_vec(k)), 32'(3'b100));
        for (int i = 0; i < 6; i++) begin
            step(pl[5-i]);
            chk("addr_phase_en", 32'(en_vec(k)), (i < 5) ? 32'(3'b100) : 32'(3'b010));
            chk("port_line_hold", 32'({pt[k], ln[k]}), (i < 5) ? 32'(last_pl[k]) : 32'(pl));
        end
        for (int i = 0; i < 6; i++) begin
            step(s[5-i]);
            chk("size_phase_en", 32'(en_vec(k)),
                (i < 5) ? 32'(3'b010) : ((s != 6'd0) ? 32'(3'b001) : 32'(3'b000)));
            chk("size_hold", 32'(sz[k]), (i < 5) ? 32'(last_sz[k]) : 32'(s));
        end
        last_pl[k] = pl;
        last_sz[k] = s;
        for (int j = 1; j <= int'(s); j++) begin
            step(1'($urandom_range(0, 1)));
            if (abort && j == 1) begin
                rst = 1'b1;
                step(1'b1);
                chk("abort_outputs_cleared", 32'(out_all(k)), 32'(0));
                rst = 1'b0;
                last_pl[k] = '0;
                last_sz[k] = '0;
                return;
            end
            chk("payload_en", 32'(en_vec(k)), (j < int'(s)) ? 32'(3'b001) : 32'(3'b000));
        end
        chk("frame_done_pulse", 32'(fd[k]), 32'(1));
    endtask

    // Scoreboard consumer: each frame_done pops the oldest expected frame.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (fd[k] === 1'b1) begin
                chk("frame_done_expected", 32'(q.size() > 0), 32'(1));
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_instance", 32'(k), 32'(e.k));
                    chk("sb_port", 32'(pt[k]), 32'(e.p));
                    chk("sb_line", 32'(ln[k]), 32'(e.l));
                    chk("sb_size", 32'(sz[k]), 32'(e.s));
                    chk("sb_addr_cycles", 32'(ca[k]), 32'(6));
                    chk("sb_size_cycles", 32'(cs[k]), 32'(6));
                    chk("sb_send_cycles", 32'(cd[k]), 32'(e.s));
                end
                ca[k] = 0; cs[k] = 0; cd[k] = 0;
            end else if (bsy[k] !== 1'b1) begin
                ca[k] = 0; cs[k] = 0; cd[k] = 0;
            end else begin
                ca[k] += (aen[k] === 1'b1) ? 1 : 0;
                cs[k] += (sen[k] === 1'b1) ? 1 : 0;
                cd[k] += (snd[k] === 1'b1) ? 1 : 0;
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        sel = 0;
        ser = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            last_pl[k] = '0; last_sz[k] = '0;
            ca[k] = 0; cs[k] = 0; cd[k] = 0;
        end

        // Reset with serIn toggling, then idle high
        step(1'b0);
        chk("reset_outputs_c1", 32'(out_all(0)), 32'(0));
        step(1'b1);
        chk("reset_outputs_c2", 32'(out_all(0)), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("idle_busy", 32'(bsy[0]), 32'(0));
        end

        // Nominal frame, GAP=1
        send_frame(0, 4'b1011, 2'b01, 6'd3, 1'b0);
        chk("guard_busy", 32'(bsy[0]), 32'(1));
        step(1'b1);
        chk("frame_done_single", 32'(fd[0]), 32'(0));
        chk("idle_after_guard", 32'(bsy[0]), 32'(0));

        // Zero-size frame
        send_frame(0, 4'b1011, 2'b01, 6'd0, 1'b0);
        step(1'b1);
        chk("zero_size_idle", 32'(bsy[0]), 32'(0));

        // GAP=3: zeros during guard are ignored
        send_frame(1, 4'b0110, 2'b10, 6'd2, 1'b0);
        chk("gap3_guard1_busy", 32'(bsy[1]), 32'(1));
        step(1'b0);
        chk("gap3_guard2", 32'({bsy[1], aen[1]}), 32'(2'b10));
        step(1'b0);
        chk("gap3_guard3", 32'({bsy[1], aen[1]}), 32'(2'b10));
        step(1'b0);
        chk("gap3_back_idle", 32'({bsy[1], aen[1]}), 32'(2'b00));
        send_frame(1, 4'b1001, 2'b11, 6'd1, 1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        chk("gap3_idle_end", 32'(bsy[1]), 32'(0));

        // GAP=0: back-to-back frames
        send_frame(2, 4'b1100, 2'b00, 6'd4, 1'b0);
        chk("gap0_done_is_idle", 32'(bsy[2]), 32'(0));
        send_frame(2, 4'b0011, 2'b11, 6'd2, 1'b0);
        chk("gap0_second_idle", 32'(bsy[2]), 32'(0));
        step(1'b1);

        // Abort during the 2nd payload cycle
        send_frame(0, 4'b0101, 2'b10, 6'd5, 1'b1);
        step(1'b1);
        chk("abort_stays_idle", 32'(out_all(0)), 32'(0));

        // Maximum payload length
        send_frame(0, 4'b1111, 2'b11, 6'd63, 1'b0);
        step(1'b1);
        chk("max_no_second_done", 32'(fd[0]), 32'(0));
        step(1'b1);

        chk("scoreboard_drained", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
